// File: rtl/control_seq_if.sv
// Sequencer <-> core control bundle: run/opcode inputs plus every datapath strobe.
// master = sequencer side, slave = core/top-level side.
interface control_seq_if #(
  parameter int WIDTH_MAIN  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   run;
  logic [WIDTH_MAIN-1:0]  main_in;
  logic [3:0]             reg_assert_main;
  logic [3:0]             reg_load_main;
  logic [3:0]             reg_assert_lhs;
  logic [3:0]             reg_assert_rhs;
  logic                   const1_load_mem;
  logic                   const1_assert_main;
  logic                   pcra0_assert_addr;
  logic                   pcra0_inc;
  logic                   mem_busdir;
  logic                   mem_assert_main;
  logic                   alu_assert_main;
  logic [3:0]             alu_operation;
  logic [WIDTH_MAIN-1:0]  ir;
  logic                   halted;
  logic [COUNT_WIDTH-1:0] instr_count;

  modport master (
    input  run, main_in,
    output reg_assert_main, reg_load_main, reg_assert_lhs, reg_assert_rhs,
           const1_load_mem, const1_assert_main, pcra0_assert_addr, pcra0_inc,
           mem_busdir, mem_assert_main, alu_assert_main, alu_operation,
           ir, halted, instr_count
  );

  modport slave (
    output run, main_in,
    input  reg_assert_main, reg_load_main, reg_assert_lhs, reg_assert_rhs,
           const1_load_mem, const1_assert_main, pcra0_assert_addr, pcra0_inc,
           mem_busdir, mem_assert_main, alu_assert_main, alu_operation,
           ir, halted, instr_count
  );
endinterface

// File: rtl/control_seq.sv
// Fetch/execute microsequencer: 2 cycles per NOP/MOV/ALU/HLT, 3 per LDI; no backpressure,
// run only gates new fetches, an instruction in flight always completes.
module control_seq #(
  parameter int WIDTH_MAIN  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  control_seq_if.master cs_if
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH_MAIN-1:0]  ir_q, ir_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [3:0] ram, rlm, lhs, rhs, alu_op;
  logic       c1_load, c1_assert, pc_addr, pc_inc, busdir, mem_main, alu_main, halt_o;

  logic [1:0] cls, dst_hi, mov_dst, mov_src;
  assign cls     = ir_q[WIDTH_MAIN-1 -: 2];
  assign dst_hi  = ir_q[5:4];
  assign mov_dst = ir_q[3:2];
  assign mov_src = ir_q[1:0];

  function automatic logic [3:0] sel(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    count_d   = count_q;
    ram       = 4'b0000;
    rlm       = 4'b0000;
    lhs       = 4'b0000;
    rhs       = 4'b0000;
    alu_op    = 4'b0000;
    c1_load   = 1'b0;
    c1_assert = 1'b0;
    pc_addr   = 1'b0;
    pc_inc    = 1'b0;
    busdir    = 1'b0;
    mem_main  = 1'b0;
    alu_main  = 1'b0;
    halt_o    = 1'b0;

    unique case (state_q)
      S_BOOT: state_d = S_FETCH;

      S_FETCH: begin
        if (cs_if.run) begin
          pc_addr  = 1'b1;
          busdir   = 1'b1;
          mem_main = 1'b1;
          pc_inc   = 1'b1;
          ir_d     = cs_if.main_in;
          state_d  = S_EXEC1;
        end
      end

      S_EXEC1: begin
        unique case (cls)
          2'b00: begin
            count_d = count_q + COUNT_WIDTH'(1);
            state_d = (ir_q == WIDTH_MAIN'(8'h3F)) ? S_HALT : S_FETCH;
          end
          2'b01: begin
            // Self-move would assert and load the same register; treat as NOP.
            if (mov_dst != mov_src) begin
              ram = sel(mov_src);
              rlm = sel(mov_dst);
            end
            count_d = count_q + COUNT_WIDTH'(1);
            state_d = S_FETCH;
          end
          2'b10: begin
            pc_addr = 1'b1;
            c1_load = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_EXEC2;
          end
          default: begin
            lhs      = 4'b0001;
            rhs      = 4'b0010;
            alu_op   = ir_q[3:0];
            alu_main = 1'b1;
            rlm      = sel(dst_hi);
            count_d  = count_q + COUNT_WIDTH'(1);
            state_d  = S_FETCH;
          end
        endcase
      end

      S_EXEC2: begin
        c1_assert = 1'b1;
        rlm       = sel(dst_hi);
        count_d   = count_q + COUNT_WIDTH'(1);
        state_d   = S_FETCH;
      end

      S_HALT: halt_o = 1'b1;

      default: state_d = S_BOOT;
    endcase
  end

  assign cs_if.reg_assert_main    = ram;
  assign cs_if.reg_load_main      = rlm;
  assign cs_if.reg_assert_lhs     = lhs;
  assign cs_if.reg_assert_rhs     = rhs;
  assign cs_if.const1_load_mem    = c1_load;
  assign cs_if.const1_assert_main = c1_assert;
  assign cs_if.pcra0_assert_addr  = pc_addr;
  assign cs_if.pcra0_inc          = pc_inc;
  assign cs_if.mem_busdir         = busdir;
  assign cs_if.mem_assert_main    = mem_main;
  assign cs_if.alu_assert_main    = alu_main;
  assign cs_if.alu_operation      = alu_op;
  assign cs_if.ir                 = ir_q;
  assign cs_if.halted             = halt_o;
  assign cs_if.instr_count        = count_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed vector bench for control_seq: per-cycle table plus a counter-wrap sequence.
module tb_control_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset2 = 1'b0;
  always #5 clk = ~clk;

  control_seq_if #(.WIDTH_MAIN(8), .COUNT_WIDTH(16)) cs ();
  control_seq_if #(.WIDTH_MAIN(8), .COUNT_WIDTH(4))  cs2 ();

  control_seq #(.WIDTH_MAIN(8), .COUNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .cs_if (cs.master)
  );

  control_seq #(.WIDTH_MAIN(8), .COUNT_WIDTH(4)) dut_wrap (
    .clk   (clk),
    .reset (reset2),
    .cs_if (cs2.master)
  );

  typedef struct packed {
    logic [3:0]  ram, rlm, lhs, rhs;
    logic        c1l, c1a, paa, pinc, mbd, mam, aam;
    logic [3:0]  op;
    logic        hlt;
    logic [7:0]  ir;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       run;
    logic [7:0] din;
    exp_t       exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t e_base(input logic [7:0] ir, input logic [15:0] cnt);
    exp_t e;
    e = '0;
    e.ir = ir;
    e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic [7:0] ir, input logic [15:0] cnt);
    exp_t e;
    e = e_base(ir, cnt);
    e.paa = 1'b1; e.mbd = 1'b1; e.mam = 1'b1; e.pinc = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_ldi1(input logic [7:0] ir, input logic [15:0] cnt);
    exp_t e;
    e = e_base(ir, cnt);
    e.paa = 1'b1; e.c1l = 1'b1; e.pinc = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_ldi2(input logic [7:0] ir, input logic [15:0] cnt, input logic [3:0] dst);
    exp_t e;
    e = e_base(ir, cnt);
    e.c1a = 1'b1; e.rlm = dst;
    return e;
  endfunction

  function automatic exp_t e_mov(input logic [7:0] ir, input logic [15:0] cnt,
                                 input logic [3:0] src, input logic [3:0] dst);
    exp_t e;
    e = e_base(ir, cnt);
    e.ram = src; e.rlm = dst;
    return e;
  endfunction

  function automatic exp_t e_alu(input logic [7:0] ir, input logic [15:0] cnt,
                                 input logic [3:0] dst, input logic [3:0] op);
    exp_t e;
    e = e_base(ir, cnt);
    e.lhs = 4'b0001; e.rhs = 4'b0010; e.op = op; e.aam = 1'b1; e.rlm = dst;
    return e;
  endfunction

  function automatic exp_t e_halt(input logic [7:0] ir, input logic [15:0] cnt);
    exp_t e;
    e = e_base(ir, cnt);
    e.hlt = 1'b1;
    return e;
  endfunction

  task automatic add(input string name, input logic rst_n, input logic run,
                     input logic [7:0] din, input exp_t exp);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.run = run; v.din = din; v.exp = exp;
    tbl.push_back(v);
  endtask

  function automatic exp_t observe();
    exp_t a;
    a.ram  = cs.reg_assert_main;
    a.rlm  = cs.reg_load_main;
    a.lhs  = cs.reg_assert_lhs;
    a.rhs  = cs.reg_assert_rhs;
    a.c1l  = cs.const1_load_mem;
    a.c1a  = cs.const1_assert_main;
    a.paa  = cs.pcra0_assert_addr;
    a.pinc = cs.pcra0_inc;
    a.mbd  = cs.mem_busdir;
    a.mam  = cs.mem_assert_main;
    a.aam  = cs.alu_assert_main;
    a.op   = cs.alu_operation;
    a.hlt  = cs.halted;
    a.ir   = cs.ir;
    a.cnt  = cs.instr_count;
    return a;
  endfunction

  initial begin
    exp_t act;
    int   drivers;

    cs.run = 1'b0;
    cs.main_in = 8'h00;
    cs2.run = 1'b1;
    cs2.main_in = 8'h00;

    //   name       rst run  din    expected outputs during this cycle
    add("rst",      0, 1, 8'h00, e_base (8'h00, 16'd0));
    add("boot",     1, 1, 8'h00, e_base (8'h00, 16'd0));
    add("f_ldi",    1, 1, 8'h90, e_fetch(8'h00, 16'd0));
    add("ldi1",     1, 0, 8'h5A, e_ldi1 (8'h90, 16'd0));
    add("ldi2",     1, 0, 8'h5A, e_ldi2 (8'h90, 16'd0, 4'b0010));
    add("f_mov",    1, 1, 8'h46, e_fetch(8'h90, 16'd1));
    add("mov_bc",   1, 1, 8'h00, e_mov  (8'h46, 16'd1, 4'b0100, 4'b0010));
    add("f_mov2",   1, 1, 8'h45, e_fetch(8'h46, 16'd2));
    add("mov_bb",   1, 1, 8'h00, e_base (8'h45, 16'd2));
    add("f_mov3",   1, 1, 8'h4C, e_fetch(8'h45, 16'd3));
    add("mov_da",   1, 1, 8'h00, e_mov  (8'h4C, 16'd3, 4'b0001, 4'b1000));
    add("f_alu",    1, 1, 8'hF3, e_fetch(8'h4C, 16'd4));
    add("alu_d3",   1, 1, 8'h00, e_alu  (8'hF3, 16'd4, 4'b1000, 4'd3));
    add("f_alu2",   1, 1, 8'hC5, e_fetch(8'hF3, 16'd5));
    add("alu_a5",   1, 1, 8'h00, e_alu  (8'hC5, 16'd5, 4'b0001, 4'd5));
    add("f_nop",    1, 1, 8'h00, e_fetch(8'hC5, 16'd6));
    add("nop",      1, 1, 8'h3F, e_base (8'h00, 16'd6));
    add("idle1",    1, 0, 8'h3F, e_base (8'h00, 16'd7));
    add("idle2",    1, 0, 8'h3F, e_base (8'h00, 16'd7));
    add("f_hlt",    1, 1, 8'h3F, e_fetch(8'h00, 16'd7));
    add("hlt",      1, 1, 8'h00, e_base (8'h3F, 16'd7));
    add("halt0",    1, 0, 8'h00, e_halt (8'h3F, 16'd8));
    add("halt1",    1, 1, 8'h90, e_halt (8'h3F, 16'd8));
    add("halt2",    1, 0, 8'h90, e_halt (8'h3F, 16'd8));
    add("rst2",     0, 1, 8'h00, e_base (8'h00, 16'd0));
    add("boot2",    1, 1, 8'h00, e_base (8'h00, 16'd0));
    add("f_ldi2",   1, 1, 8'h95, e_fetch(8'h00, 16'd0));
    add("ldi1b",    1, 1, 8'h00, e_ldi1 (8'h95, 16'd0));
    add("ldi2b",    1, 1, 8'h00, e_ldi2 (8'h95, 16'd0, 4'b0010));
    add("f_ldi3",   1, 1, 8'h96, e_fetch(8'h95, 16'd1));
    add("ldi1c",    1, 1, 8'h00, e_ldi1 (8'h96, 16'd1));
    add("rst_ex2",  0, 1, 8'h00, e_base (8'h00, 16'd0));
    add("boot3",    1, 0, 8'h00, e_base (8'h00, 16'd0));
    add("idle3",    1, 0, 8'h00, e_base (8'h00, 16'd0));

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (i == 31) begin
        #2;
        total++;
        if (cs.const1_assert_main !== 1'b1) begin
          bad++;
          $display("FAIL pre_rst_ex2: const1_assert_main got %b want 1", cs.const1_assert_main);
        end
      end
      reset = tbl[i].rst_n;
      cs.run = tbl[i].run;
      cs.main_in = tbl[i].din;
      #1;
      act = observe();
      total++;
      if (act !== tbl[i].exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", tbl[i].name, act, tbl[i].exp);
      end
      drivers = $countones({cs.reg_assert_main, cs.const1_assert_main,
                            cs.mem_assert_main, cs.alu_assert_main});
      total++;
      if (drivers > 1) begin
        bad++;
        $display("FAIL onehot_%s: got %0d main drivers want <=1", tbl[i].name, drivers);
      end
    end

    // Counter wrap on a 4-bit instance: 16 NOPs take the count from 0 back to 0.
    @(negedge clk);
    reset2 = 1'b1;
    #1;
    total++;
    if (cs2.instr_count !== 4'd0 || cs2.pcra0_inc !== 1'b0) begin
      bad++;
      $display("FAIL wrap_boot: got cnt=%h inc=%b want cnt=0 inc=0", cs2.instr_count, cs2.pcra0_inc);
    end
    @(negedge clk);
    for (int i = 0; i <= 16; i++) begin
      logic [3:0] want;
      want = 4'(i);
      #1;
      total++;
      if (cs2.instr_count !== want || cs2.pcra0_inc !== 1'b1) begin
        bad++;
        $display("FAIL wrap_%0d: got cnt=%h inc=%b want cnt=%h inc=1",
                 i, cs2.instr_count, cs2.pcra0_inc, want);
      end
      @(negedge clk);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
